id_ex_issue_stage: RTL and testbench
====================================

// Module: id_ex_issue_stage
// PURPOSE
//  Pipeline register and operand-select stage directly upstream of the ALU: captures decoded instructions under a
//  valid/ready handshake and drives ALU src1_i/src2_i/ctrl_i from registered state. Resolves RAW hazards by
//  forwarding from EX/MEM and MEM/WB, and detects load-use hazards (stall + bubble). Supports flush and EX back-pressure.
// PARAMETERS
//  DATA_W  32  operand/result width
//  REG_AW  5   register-index width
//  CTRL_W  4   ALU control width (0010 ADD, 0110 SUB, 0001 AND, 0000 OR, 1101 NOR, 0111 SLT)
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  id_valid_i   in   1       decode presents an instruction
//  id_ready_o   out  1       stage accepts it this cycle
//  id_rs_i      in   REG_AW  rs index;  id_rt_i in REG_AW rt index;  id_rd_i in REG_AW destination index
//  id_rs_data_i in   DATA_W  register-file rs value;  id_rt_data_i in DATA_W rt value;  id_imm_i in DATA_W sign-extended imm
//  id_alusrc_i  in   1       1: src2 = imm, 0: src2 = rt value
//  id_ctrl_i    in   CTRL_W  ALU op;  id_regwrite_i / id_memread_i / id_memwrite_i / id_memtoreg_i  in 1 each
//  flush_i      in   1       kill held and incoming instruction (branch taken)
//  ex_ready_i   in   1       EX stage consumes the held instruction this cycle
//  exm_regwrite_i in 1; exm_rd_i in REG_AW; exm_result_i in DATA_W   EX/MEM forward source
//  mwb_regwrite_i in 1; mwb_rd_i in REG_AW; mwb_wdata_i  in DATA_W   MEM/WB forward source
//  ex_valid_o   out  1       held instruction valid (bubbles are 0)
//  src1_o       out  DATA_W  to ALU src1_i;  src2_o out DATA_W to ALU src2_i;  ctrl_o out CTRL_W to ALU ctrl_i
//  ex_rd_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_rt_data_o (forwarded, for stores)  out
// BEHAVIOUR
//  - Reset (rst_n=0, async): ex_valid_o=0, all held fields 0 -> src1_o=src2_o=0, ctrl_o=0000, all ctrl outputs 0.
//  - States: EMPTY (valid_q=0), HOLD (valid_q=1). Capture on id_valid_i & id_ready_o; 1-cycle latency ID->EX.
//  - advance = ~valid_q | ex_ready_i. load_use = valid_q & memread_q & rd_q!=0 & (rd_q==id_rs_i | rd_q==id_rt_i).
//  - id_ready_o = advance & ~load_use & ~flush_i (combinational; must not depend on id_valid_i).
//  - On advance with load_use: load a bubble (valid_q=0, regwrite/memread/memwrite cleared); decode retries next cycle.
//  - On advance without capture: valid_q<=0. Not advancing: all held state unchanged (ex_ready_i=0 stalls).
//  - flush_i=1: valid_q<=0 next edge, regardless of ex_ready_i/id_valid_i; flush wins over every other event.
//  - Forwarding (combinational, per operand, on registered rs_q/rt_q): if exm_regwrite_i & exm_rd_i!=0 &
//    exm_rd_i==idx -> exm_result_i; else if mwb_regwrite_i & mwb_rd_i!=0 & mwb_rd_i==idx -> mwb_wdata_i;
//    else held data. EX/MEM has priority. Index 0 never forwarded.
//  - src2_o = alusrc_q ? imm_q : forwarded rt. ex_rt_data_o is always forwarded rt. ctrl_o = ctrl_q.
//  - While stalled (ex_ready_i=0) forwarded values may change cycle-to-cycle as forward sources change; held raw data
//    never changes.
//  - Reset mid-operation: held instruction dropped, no partial state survives.
//  - All widths exact DATA_W; no extension or truncation in this block.
// STRUCTURE
//  - Shared package: ALU op codes (ADD/SUB/AND/OR/NOR/SLT), DATA_W/REG_AW/CTRL_W defaults, control bundle fields.
//  - One sub-module: fwd_mux (idx, held data, two forward sources -> operand), instantiated twice (rs, rt).
// TESTING
//  1. Reset, then issue ADD rs=1(5) rt=2(7) alusrc=0 -> next cycle ex_valid_o=1, src1_o=5, src2_o=7, ctrl_o=0010.
//  2. Held rs=3 data 1, exm_regwrite=1 rd=3 result 0x10, mwb rd=3 wdata 0x20 -> src1_o=0x10; exm_rd=0 -> 0x20.
//  3. Held LW rd=4 memread=1, incoming rs=4 -> id_ready_o=0, next cycle ex_valid_o=0 (bubble), then accepted.
//  4. ex_ready_i=0 for 3 cycles with id_valid_i=1 -> id_ready_o=0, ctrl_o/ex_rd_o stable; release -> new instr.
//  5. flush_i=1 with held and incoming valid -> next cycle ex_valid_o=0, incoming not captured.
//  6. Assert rst_n=0 mid-HOLD -> ex_valid_o=0, src1_o=src2_o=0 immediately (async).

Source files
------------

// File: rtl/id_ex_issue_stage_pkg.sv
// rtl/id_ex_issue_stage_pkg.sv - shared widths, ALU op codes, control bundle and state encoding for the ID/EX issue stage
package id_ex_issue_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CTRL_W_DEF = 4;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0000;
    localparam logic [3:0] ALU_NOR = 4'b1101;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic alusrc;
    } ctrl_bundle_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } issue_state_t;

endpackage

// File: rtl/id_ex_issue_stage_fwd_mux.sv
// rtl/id_ex_issue_stage_fwd_mux.sv - per-operand RAW forwarding select, EX/MEM over MEM/WB over held data
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] held_data,
    input  logic              exm_regwrite,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_regwrite,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_wdata,
    output logic [DATA_W-1:0] operand
);

    always_comb begin
        operand = held_data;
        // Register 0 is hard-wired, so a write to it must never be forwarded.
        if (exm_regwrite && (exm_rd != '0) && (exm_rd == idx)) begin
            operand = exm_result;
        end else if (mwb_regwrite && (mwb_rd != '0) && (mwb_rd == idx)) begin
            operand = mwb_wdata;
        end
    end

endmodule

// File: rtl/id_ex_issue_stage.sv
// rtl/id_ex_issue_stage.sv - ID/EX pipeline register with operand forwarding, load-use stall, flush and back-pressure
module id_ex_issue_stage
    import id_ex_issue_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic              id_alusrc_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              id_memwrite_i,
    input  logic              id_memtoreg_i,
    input  logic              flush_i,
    input  logic              ex_ready_i,
    input  logic              exm_regwrite_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic [DATA_W-1:0] exm_result_i,
    input  logic              mwb_regwrite_i,
    input  logic [REG_AW-1:0] mwb_rd_i,
    input  logic [DATA_W-1:0] mwb_wdata_i,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] src1_o,
    output logic [DATA_W-1:0] src2_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_regwrite_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_memtoreg_o,
    output logic [DATA_W-1:0] ex_rt_data_o
);

    issue_state_t      state_q, state_d;
    ctrl_bundle_t      flags_q;
    logic [REG_AW-1:0] rs_q, rt_q, rd_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    logic [CTRL_W-1:0] alu_q;
    logic              advance, load_use, capture;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        advance    = (state_q == ST_EMPTY) || ex_ready_i;
        load_use   = (state_q == ST_HOLD) && flags_q.memread && (rd_q != '0) &&
                     ((rd_q == id_rs_i) || (rd_q == id_rt_i));
        id_ready_o = advance && !load_use && !flush_i;
        capture    = id_valid_i && id_ready_o;
        state_d    = state_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else if (advance) begin
            state_d = capture ? ST_HOLD : ST_EMPTY;
        end
    end

    // Any slot update that is not a capture leaves a bubble whose side-effect flags are cleared.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
        end else if (capture) begin
            flags_q   <= '{regwrite: id_regwrite_i, memread: id_memread_i, memwrite: id_memwrite_i,
                           memtoreg: id_memtoreg_i, alusrc: id_alusrc_i};
            rs_q      <= id_rs_i;
            rt_q      <= id_rt_i;
            rd_q      <= id_rd_i;
            rs_data_q <= id_rs_data_i;
            rt_data_q <= id_rt_data_i;
            imm_q     <= id_imm_i;
            alu_q     <= id_ctrl_i;
        end else if (flush_i || advance) begin
            flags_q.regwrite <= 1'b0;
            flags_q.memread  <= 1'b0;
            flags_q.memwrite <= 1'b0;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .idx(rs_q), .held_data(rs_data_q),
        .exm_regwrite(exm_regwrite_i), .exm_rd(exm_rd_i), .exm_result(exm_result_i),
        .mwb_regwrite(mwb_regwrite_i), .mwb_rd(mwb_rd_i), .mwb_wdata(mwb_wdata_i),
        .operand(fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .idx(rt_q), .held_data(rt_data_q),
        .exm_regwrite(exm_regwrite_i), .exm_rd(exm_rd_i), .exm_result(exm_result_i),
        .mwb_regwrite(mwb_regwrite_i), .mwb_rd(mwb_rd_i), .mwb_wdata(mwb_wdata_i),
        .operand(fwd_rt)
    );

    assign ex_valid_o    = (state_q == ST_HOLD);
    assign src1_o        = fwd_rs;
    assign src2_o        = flags_q.alusrc ? imm_q : fwd_rt;
    assign ctrl_o        = alu_q;
    assign ex_rd_o       = rd_q;
    assign ex_regwrite_o = flags_q.regwrite;
    assign ex_memread_o  = flags_q.memread;
    assign ex_memwrite_o = flags_q.memwrite;
    assign ex_memtoreg_o = flags_q.memtoreg;
    assign ex_rt_data_o  = fwd_rt;

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// tb/tb_id_ex_issue_stage.sv - self-checking bench for id_ex_issue_stage against a transaction-level slot model
module tb_id_ex_issue_stage;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        id_valid_i, id_ready_o;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic        id_alusrc_i;
    logic [3:0]  id_ctrl_i;
    logic        id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i;
    logic        flush_i, ex_ready_i;
    logic        exm_regwrite_i, mwb_regwrite_i;
    logic [4:0]  exm_rd_i, mwb_rd_i;
    logic [31:0] exm_result_i, mwb_wdata_i;
    logic        ex_valid_o;
    logic [31:0] src1_o, src2_o, ex_rt_data_o;
    logic [3:0]  ctrl_o;
    logic [4:0]  ex_rd_o;
    logic        ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Model of the single instruction slot feeding EX.
    logic        m_valid, m_bubble;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic        m_alusrc, m_rw, m_mr, m_mw, m_mtr;
    logic [3:0]  m_ctrl;

    id_ex_issue_stage dut (
        .clk_i(clk_i), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
        .id_alusrc_i(id_alusrc_i), .id_ctrl_i(id_ctrl_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i),
        .exm_regwrite_i(exm_regwrite_i), .exm_rd_i(exm_rd_i), .exm_result_i(exm_result_i),
        .mwb_regwrite_i(mwb_regwrite_i), .mwb_rd_i(mwb_rd_i), .mwb_wdata_i(mwb_wdata_i),
        .ex_valid_o(ex_valid_o), .src1_o(src1_o), .src2_o(src2_o), .ctrl_o(ctrl_o),
        .ex_rd_o(ex_rd_o), .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
        .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o), .ex_rt_data_o(ex_rt_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] held);
        if (exm_regwrite_i && exm_rd_i != 0 && exm_rd_i == idx) return exm_result_i;
        if (mwb_regwrite_i && mwb_rd_i != 0 && mwb_rd_i == idx) return mwb_wdata_i;
        return held;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_bubble = 1;
        {m_rs, m_rt, m_rd, m_rsd, m_rtd, m_imm, m_alusrc, m_ctrl} = '0;
        {m_rw, m_mr, m_mw, m_mtr} = '0;
    endtask

    task automatic idle_inputs();
        id_valid_i = 0; id_rs_i = 0; id_rt_i = 0; id_rd_i = 0;
        id_rs_data_i = 0; id_rt_data_i = 0; id_imm_i = 0; id_alusrc_i = 0; id_ctrl_i = 0;
        {id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i} = '0;
        flush_i = 0; ex_ready_i = 1;
        exm_regwrite_i = 0; exm_rd_i = 0; exm_result_i = 0;
        mwb_regwrite_i = 0; mwb_rd_i = 0; mwb_wdata_i = 0;
    endtask

    task automatic issue(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd, imm,
                         input logic alusrc, input logic [3:0] op, input logic rw, mr);
        id_valid_i = 1; id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
        id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = imm;
        id_alusrc_i = alusrc; id_ctrl_i = op;
        id_regwrite_i = rw; id_memread_i = mr; id_memwrite_i = 0; id_memtoreg_i = mr;
    endtask

    // Check outputs at the falling edge, then apply the slot rules at the rising edge.
    task automatic cycle();
        logic adv, lu, rdy;
        @(negedge clk_i);
        adv = !m_valid || ex_ready_i;
        lu  = m_valid && m_mr && m_rd != 0 && (m_rd == id_rs_i || m_rd == id_rt_i);
        rdy = adv && !lu && !flush_i;
        check("id_ready", id_ready_o, rdy);
        check("ex_valid", ex_valid_o, m_valid);
        if (m_valid) begin
            check("src1", src1_o, fwd(m_rs, m_rsd));
            check("src2", src2_o, m_alusrc ? m_imm : fwd(m_rt, m_rtd));
            check("rt_data", ex_rt_data_o, fwd(m_rt, m_rtd));
            check("ctrl", ctrl_o, m_ctrl);
            check("rd", ex_rd_o, m_rd);
            check("memtoreg", ex_memtoreg_o, m_mtr);
        end
        if (m_valid || m_bubble) begin
            check("regwrite", ex_regwrite_o, m_rw);
            check("memread", ex_memread_o, m_mr);
            check("memwrite", ex_memwrite_o, m_mw);
        end
        @(posedge clk_i);
        if (flush_i) begin
            m_valid = 0; m_bubble = 0;
        end else if (adv) begin
            if (lu) begin
                m_valid = 0; m_bubble = 1; m_rw = 0; m_mr = 0; m_mw = 0;
            end else if (id_valid_i) begin
                m_valid = 1; m_bubble = 0;
                m_rs = id_rs_i; m_rt = id_rt_i; m_rd = id_rd_i;
                m_rsd = id_rs_data_i; m_rtd = id_rt_data_i; m_imm = id_imm_i;
                m_alusrc = id_alusrc_i; m_ctrl = id_ctrl_i;
                m_rw = id_regwrite_i; m_mr = id_memread_i; m_mw = id_memwrite_i; m_mtr = id_memtoreg_i;
            end else begin
                m_valid = 0; m_bubble = 0;
            end
        end
        #1;
    endtask

    task automatic rand_inputs();
        logic [3:0] ops [6];
        ops = '{4'b0010, 4'b0110, 4'b0001, 4'b0000, 4'b1101, 4'b0111};
        id_valid_i = ($urandom % 10) < 7;
        id_rs_i = 5'($urandom % 4); id_rt_i = 5'($urandom % 4); id_rd_i = 5'($urandom % 4);
        id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
        id_alusrc_i = 1'($urandom); id_ctrl_i = ops[$urandom % 6];
        id_regwrite_i = 1'($urandom); id_memread_i = ($urandom % 10) < 3;
        id_memwrite_i = 1'($urandom); id_memtoreg_i = 1'($urandom);
        flush_i = ($urandom % 10) == 0; ex_ready_i = ($urandom % 4) != 0;
        exm_regwrite_i = 1'($urandom); exm_rd_i = 5'($urandom % 4); exm_result_i = $urandom;
        mwb_regwrite_i = 1'($urandom); mwb_rd_i = 5'($urandom % 4); mwb_wdata_i = $urandom;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", ex_valid_o, 0);
        check("rst_src1", src1_o, 0);
        check("rst_src2", src2_o, 0);
        check("rst_ctrl", ctrl_o, 0);
        check("rst_flags", {ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o}, 0);
        rst_n = 1;

        // Basic ADD issue, one cycle ID->EX.
        issue(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 4'b0010, 1'b1, 1'b0);
        cycle();
        idle_inputs(); ex_ready_i = 0;
        #1;
        check("t1_valid", ex_valid_o, 1);
        check("t1_src1", src1_o, 5);
        check("t1_src2", src2_o, 7);
        check("t1_ctrl", ctrl_o, 4'b0010);
        cycle();

        // Forwarding priority on held rs=3.
        ex_ready_i = 1;
        issue(5'd3, 5'd6, 5'd8, 32'd1, 32'd9, 32'd0, 1'b0, 4'b0110, 1'b1, 1'b0);
        cycle();
        idle_inputs(); ex_ready_i = 0;
        exm_regwrite_i = 1; exm_rd_i = 3; exm_result_i = 32'h10;
        mwb_regwrite_i = 1; mwb_rd_i = 3; mwb_wdata_i = 32'h20;
        #1;
        check("t2_exm", src1_o, 32'h10);
        cycle();
        exm_rd_i = 0;
        #1;
        check("t2_mwb", src1_o, 32'h20);
        cycle();

        // Load-use hazard: stall then accept.
        idle_inputs();
        issue(5'd1, 5'd2, 5'd4, 32'd0, 32'd0, 32'd8, 1'b1, 4'b0010, 1'b1, 1'b1);
        cycle();
        issue(5'd4, 5'd5, 5'd6, 32'd11, 32'd12, 32'd0, 1'b0, 4'b0001, 1'b1, 1'b0);
        #1;
        check("t3_ready", id_ready_o, 0);
        cycle();
        check("t3_bubble", ex_valid_o, 0);
        cycle();
        check("t3_accept", ex_valid_o, 1);
        check("t3_rd", ex_rd_o, 6);

        // EX back-pressure for three cycles.
        issue(5'd7, 5'd9, 5'd10, 32'd1, 32'd2, 32'd0, 1'b0, 4'b0111, 1'b1, 1'b0);
        ex_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_ready", id_ready_o, 0);
            check("t4_ctrl", ctrl_o, 4'b0001);
            check("t4_rd", ex_rd_o, 6);
            cycle();
        end
        ex_ready_i = 1;
        cycle();
        check("t4_new_rd", ex_rd_o, 10);

        // Flush kills held and incoming.
        issue(5'd1, 5'd1, 5'd12, 32'd3, 32'd3, 32'd0, 1'b0, 4'b0000, 1'b1, 1'b0);
        flush_i = 1;
        cycle();
        check("t5_flush", ex_valid_o, 0);
        flush_i = 0;

        // Asynchronous reset mid-HOLD.
        issue(5'd1, 5'd2, 5'd13, 32'h55, 32'h66, 32'd0, 1'b0, 4'b0010, 1'b1, 1'b0);
        cycle();
        idle_inputs(); ex_ready_i = 0;
        #2;
        rst_n = 0;
        #1;
        check("t6_valid", ex_valid_o, 0);
        check("t6_src1", src1_o, 0);
        check("t6_src2", src2_o, 0);
        model_reset();
        @(negedge clk_i);
        rst_n = 1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
